ahb_addr_decoder: RTL and testbench

//  AHB address decoder with built-in default slave, directly upstream of ahb_multiplexor.

---
 rtl/ahb_pkg.sv | 17 +
 rtl/ahb_default_slave.sv | 42 ++++
 rtl/ahb_addr_decoder.sv | 60 ++++++
 tb/tb_ahb_addr_decoder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB transfer, select-code and default-slave state encodings
package ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam int SEL_NONE       = 0;
  localparam int SEL_DEFAULT    = 1;
  localparam int SEL_SLAVE_BASE = 2;

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - default slave giving the two-cycle ERROR response and counting unmapped transfers
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       accept_unmapped,
  output logic       readyout,
  output logic       resp,
  output logic [7:0] err_cnt
);

  logic [1:0] state;
  logic [1:0] state_next;

  always_comb begin
    state_next = DS_IDLE;
    case (state)
      DS_IDLE: state_next = accept_unmapped ? DS_ERR1 : DS_IDLE;
      DS_ERR1: state_next = DS_ERR2;
      DS_ERR2: state_next = accept_unmapped ? DS_ERR1 : DS_IDLE;
      default: state_next = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DS_IDLE;
      readyout <= 1'b1;
      resp     <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      state    <= state_next;
      readyout <= (state_next != DS_ERR1);
      resp     <= (state_next != DS_IDLE);
      // ERR1 is only ever entered from IDLE/ERR2, so this counts each new error once
      if (state_next == DS_ERR1 && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ahb_addr_decoder.sv
// rtl/ahb_addr_decoder.sv - AHB address decoder: per-slave HSEL, data-phase select code, default slave
module ahb_addr_decoder
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int SLAVE_DEVICES  = 2,
  parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int REGION_BITS    = 16,
  localparam int SEL_WIDTH     = $clog2(SLAVE_DEVICES) + 1
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rst_in,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic                      ahb_ready_in,
  output logic [SLAVE_DEVICES-1:0]  slave_hsel_out,
  output logic [SEL_WIDTH-1:0]      decoder_sel_out,
  output logic                      default_readyout_out,
  output logic                      default_resp_out,
  output logic [7:0]                err_cnt_out
);

  logic [AHB_ADDR_WIDTH-1:0] offset;
  logic [AHB_ADDR_WIDTH-1:0] idx;
  logic                      mapped;
  logic                      accept;
  logic [SEL_WIDTH-1:0]      slave_code;

  // Base compare gates the subtraction so addresses below BASE never wrap into a region
  assign offset     = ahb_addr_in - BASE_ADDR;
  assign idx        = offset >> REGION_BITS;
  assign mapped     = (ahb_addr_in >= BASE_ADDR) && (idx < AHB_ADDR_WIDTH'(SLAVE_DEVICES));
  assign accept     = ahb_ready_in & ahb_trans_in[1];
  assign slave_code = idx[SEL_WIDTH-1:0] + SEL_WIDTH'(SEL_SLAVE_BASE);

  assign slave_hsel_out = mapped ? (SLAVE_DEVICES'(1) << idx) : '0;

  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) begin
      decoder_sel_out <= SEL_WIDTH'(SEL_NONE);
    end else if (ahb_ready_in) begin
      if (!accept)
        decoder_sel_out <= SEL_WIDTH'(SEL_NONE);
      else if (mapped)
        decoder_sel_out <= slave_code;
      else
        decoder_sel_out <= SEL_WIDTH'(SEL_DEFAULT);
    end
  end

  ahb_default_slave u_default_slave (
    .clk             (ahb_clk_in),
    .rst             (ahb_rst_in),
    .accept_unmapped (accept & ~mapped),
    .readyout        (default_readyout_out),
    .resp            (default_resp_out),
    .err_cnt         (err_cnt_out)
  );

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// tb/tb_ahb_addr_decoder.sv - directed self-checking bench for ahb_addr_decoder
module tb_ahb_addr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [1:0]  trans;
  logic        ready;
  logic [1:0]  hsel;
  logic [1:0]  sel;
  logic        readyout;
  logic        resp;
  logic [7:0]  cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ahb_addr_decoder dut (
    .ahb_clk_in           (clk),
    .ahb_rst_in           (rst),
    .ahb_addr_in          (addr),
    .ahb_trans_in         (trans),
    .ahb_ready_in         (ready),
    .slave_hsel_out       (hsel),
    .decoder_sel_out      (sel),
    .default_readyout_out (readyout),
    .default_resp_out     (resp),
    .err_cnt_out          (cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
    addr  = a;
    trans = t;
    ready = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ds(input string tag, input logic ro, input logic rs, input logic [7:0] c);
    check({tag, "_readyout"}, readyout, ro);
    check({tag, "_resp"}, resp, rs);
    check({tag, "_cnt"}, cnt, c);
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 2'd0, 1'b1);
    repeat (2) step();
    check("rst_sel", sel, 2'd0);
    check_ds("rst", 1'b1, 1'b0, 8'd0);
    @(negedge clk) rst = 1'b0;
    step();

    // mapped NONSEQ to slave 0 and slave 1 (top of region)
    drive(32'h4000_0010, 2'd2, 1'b1);
    check("hsel_s0", hsel, 2'b01);
    check("sel_before_edge", sel, 2'd0);
    step();
    check("sel_s0", sel, 2'd2);
    drive(32'h4001_FFFC, 2'd2, 1'b1);
    check("hsel_s1", hsel, 2'b10);
    step();
    check("sel_s1", sel, 2'd3);
    check_ds("mapped", 1'b1, 1'b0, 8'd0);

    // just past the last region -> default slave ERROR sequence
    drive(32'h4002_0000, 2'd2, 1'b1);
    check("hsel_past_end", hsel, 2'b00);
    step();
    check("sel_default", sel, 2'd1);
    check_ds("err1_a", 1'b0, 1'b1, 8'd1);
    drive(32'h0, 2'd0, 1'b0);
    step();
    check("sel_hold_err", sel, 2'd1);
    check_ds("err2_a", 1'b1, 1'b1, 8'd1);
    drive(32'h0, 2'd0, 1'b1);
    step();
    check("sel_idle", sel, 2'd0);
    check_ds("idle_a", 1'b1, 1'b0, 8'd1);

    // just below base
    drive(32'h3FFF_FFFC, 2'd2, 1'b1);
    check("hsel_below", hsel, 2'b00);
    step();
    check("sel_below", sel, 2'd1);
    check_ds("err1_b", 1'b0, 1'b1, 8'd2);
    drive(32'h0, 2'd0, 1'b0);
    step();
    check_ds("err2_b", 1'b1, 1'b1, 8'd2);
    drive(32'h4002_0000, 2'd0, 1'b1);
    step();
    check("sel_idle_unmapped", sel, 2'd0);
    check_ds("idle_unmapped", 1'b1, 1'b0, 8'd2);
    drive(32'h5000_0000, 2'd1, 1'b1);
    step();
    check("sel_busy_unmapped", sel, 2'd0);
    check_ds("busy_unmapped", 1'b1, 1'b0, 8'd2);

    // wait states: select and FSM hold while ready is low
    drive(32'h4000_0000, 2'd2, 1'b1);
    step();
    check("sel_pre_wait", sel, 2'd2);
    drive(32'h4001_0000, 2'd2, 1'b0);
    step();
    check("sel_wait1", sel, 2'd2);
    drive(32'h5000_0000, 2'd2, 1'b0);
    step();
    check("sel_wait2", sel, 2'd2);
    check_ds("wait_unmapped", 1'b1, 1'b0, 8'd2);
    drive(32'h4001_0004, 2'd3, 1'b0);
    step();
    check("sel_wait3", sel, 2'd2);
    drive(32'h4001_0004, 2'd3, 1'b1);
    step();
    check("sel_after_wait_seq", sel, 2'd3);

    // async reset in the middle of ERR1, no clock edge needed
    drive(32'h6000_0000, 2'd2, 1'b1);
    step();
    check_ds("pre_rst_err1", 1'b0, 1'b1, 8'd3);
    rst = 1'b1;
    #1;
    check("rst_mid_sel", sel, 2'd0);
    check_ds("rst_mid", 1'b1, 1'b0, 8'd0);
    @(negedge clk) rst = 1'b0;
    drive(32'h0, 2'd0, 1'b1);
    step();

    // back-to-back errors: accept in ERR1 ignored, accept in ERR2 re-enters ERR1
    drive(32'h6000_0000, 2'd2, 1'b1);
    step();
    check_ds("b2b_err1", 1'b0, 1'b1, 8'd1);
    step();
    check_ds("b2b_err2", 1'b1, 1'b1, 8'd1);
    step();
    check_ds("b2b_reerr1", 1'b0, 1'b1, 8'd2);

    // 260 more errors saturate the counter
    repeat (520) step();
    check_ds("sat", 1'b0, 1'b1, 8'd255);
    repeat (4) step();
    check("sat_hold", cnt, 8'd255);
    drive(32'h0, 2'd0, 1'b1);
    repeat (2) step();
    check_ds("sat_idle", 1'b1, 1'b0, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
